// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one external stack between two requesters.
// Round-robin grant, one transaction in flight, registered outputs, and an
// occupancy counter (Level) kept independently of the stack's own flags.
//
// Handshake: a requester holds Req_Valid[i] (with Req_Op/Req_Data stable)
// until it sees the one-cycle Req_Ready[i] pulse. After that pulse it must
// drop or replace the request. Completion is the one-cycle Resp_Valid[i]
// pulse, which carries Resp_Err and Resp_Data.
module stack_arbiter #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = 4
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic [1:0]          Req_Valid,
    input  logic [1:0]          Req_Op,
    input  logic [2*DATA_W-1:0] Req_Data,
    output logic [1:0]          Req_Ready,
    output logic [1:0]          Resp_Valid,
    output logic [DATA_W-1:0]   Resp_Data,
    output logic                Resp_Err,
    output logic                Stk_Push,
    output logic                Stk_Pop,
    output logic [DATA_W-1:0]   Stk_Data_In,
    input  logic [DATA_W-1:0]   Stk_Data_Out,
    input  logic                Stk_Full,
    input  logic                Stk_Empty,
    output logic [LVL_W-1:0]    Level,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched transaction: winner, op (1 = pop) and illegal-op flag.
    logic cur_w, cur_op, cur_err;
    // Last granted requester; the other one wins a tie.
    logic rr_last;

    logic win, win_op, win_err, accept;
    logic [1:0]        ready_nxt, resp_valid_nxt;
    logic              push_nxt, pop_nxt, resp_err_nxt;
    logic [DATA_W-1:0] resp_data_nxt;

    assign dbg_state = state;

    // Winner selection and error classification for the request seen in IDLE.
    always_comb begin
        accept  = |Req_Valid;
        win     = 1'b0;
        if (Req_Valid == 2'b10)
            win = 1'b1;
        else if (Req_Valid == 2'b11)
            win = ~rr_last;
        win_op  = Req_Op[win];
        win_err = win_op ? Stk_Empty : Stk_Full;
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nxt      = state;
        ready_nxt      = 2'b00;
        push_nxt       = 1'b0;
        pop_nxt        = 1'b0;
        resp_valid_nxt = 2'b00;
        resp_err_nxt   = 1'b0;
        resp_data_nxt  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt      = EXEC;
                    ready_nxt[win] = 1'b1;
                    push_nxt       = !win_op && !win_err;
                    pop_nxt        = win_op && !win_err;
                end
            end
            EXEC: begin
                if (cur_op && !cur_err) begin
                    state_nxt = CAPT;
                end else begin
                    state_nxt             = RESP;
                    resp_valid_nxt[cur_w] = 1'b1;
                    resp_err_nxt          = cur_err;
                end
            end
            CAPT: begin
                state_nxt             = RESP;
                resp_valid_nxt[cur_w] = 1'b1;
                resp_data_nxt         = Stk_Data_Out;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered outputs: pulses follow the state they belong to.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Req_Ready  <= 2'b00;
            Resp_Valid <= 2'b00;
            Resp_Err   <= 1'b0;
            Resp_Data  <= '0;
            Stk_Push   <= 1'b0;
            Stk_Pop    <= 1'b0;
        end else begin
            Req_Ready  <= ready_nxt;
            Resp_Valid <= resp_valid_nxt;
            Resp_Err   <= resp_err_nxt;
            Resp_Data  <= resp_data_nxt;
            Stk_Push   <= push_nxt;
            Stk_Pop    <= pop_nxt;
        end
    end

    // Latch the accepted request; Stk_Data_In holds until the next accept.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            cur_w       <= 1'b0;
            cur_op      <= 1'b0;
            cur_err     <= 1'b0;
            rr_last     <= 1'b1;
            Stk_Data_In <= '0;
        end else if (state == IDLE && accept) begin
            cur_w       <= win;
            cur_op      <= win_op;
            cur_err     <= win_err;
            rr_last     <= win;
            Stk_Data_In <= Req_Data[(win ? DATA_W : 0) +: DATA_W];
        end
    end

    // Occupancy tracks the strobe issued in EXEC, clamped to 0..DEPTH.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Level <= '0;
        end else if (state == EXEC && !cur_err) begin
            if (!cur_op && Level < LVL_W'(DEPTH))
                Level <= Level + LVL_W'(1);
            else if (cur_op && Level != '0)
                Level <= Level - LVL_W'(1);
        end
    end

endmodule
